// File: rtl/prince_cf_pkg.sv
// prince_cf_pkg: shared constants and helpers for the PRINCE CF compression
// stage.
//   N_CF        : CF bits per lane (18).
//   SHARES      : output shares per variable (3).
//   GROUPS      : 3-bit CF groups per output variable (x or y).
//   X/Y_SHARE_MAP : the output share that each 3-bit group compresses into.
//                   Group 0 feeds share 1, group 1 feeds share 2, and
//                   group 2 feeds share 0.
//   lane_base() : first CF bit index of a lane inside the flat cf bus.
package prince_cf_pkg;

  localparam int unsigned N_CF   = 32'd18;
  localparam int unsigned SHARES = 32'd3;
  localparam int unsigned GROUPS = 32'd3;

  localparam int unsigned X_SHARE_MAP [GROUPS] = '{32'd1, 32'd2, 32'd0};
  localparam int unsigned Y_SHARE_MAP [GROUPS] = '{32'd1, 32'd2, 32'd0};

  // Lane slice helper: the lane occupies [lane_base+N_CF-1 : lane_base].
  function automatic int unsigned lane_base(input int unsigned lane);
    return lane * N_CF;
  endfunction

endpackage

// File: rtl/cf_share_xor3.sv
// cf_share_xor3: compresses three registered CF bits into one output share.
// Each share is built in its own instance, so synthesis keeps every
// compression tree separate. No XOR terms are shared between shares.
//   cf_grp : 3 registered CF bits of one group
//   share  : XOR of the three bits
module cf_share_xor3 (
  input  logic [2:0] cf_grp,
  output logic       share
);

  assign share = cf_grp[0] ^ cf_grp[1] ^ cf_grp[2];

endmodule

// File: rtl/prince_cf_compress.sv
// prince_cf_compress: two-stage valid/ready compression of the 18 masked
// component-function bits of a 3-share PRINCE S-box AND gadget pair.
// S1 registers each CF bit on its own. This register is the glitch barrier.
// S2 registers the XOR of each 3-bit group as one output share.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   flush_i      : synchronous flush; empties both stages and blocks input
//   cf_i         : CF bits; lane l at [18l+17:18l]
//   in_valid_i / in_ready_o   : upstream handshake
//   rnd_adv_o    : PRNG advance strobe, one pulse per accepted beat
//   x_o, y_o     : output shares; lane l share k at [3l+k]
//   out_valid_o / out_ready_i : downstream handshake
//
// Optional macro PRINCE_CF_ZEROIZE_EN clears data registers when their
// stage empties. With the macro defined, x_o and y_o read 0 whenever
// out_valid_o is 0.
module prince_cf_compress
  import prince_cf_pkg::*;
#(
  parameter int unsigned LANES = 32'd1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic [N_CF*LANES-1:0]   cf_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic                    rnd_adv_o,
  output logic [SHARES*LANES-1:0] x_o,
  output logic [SHARES*LANES-1:0] y_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i
);

  logic                    s1_valid_r;
  logic                    s2_valid_r;
  logic [N_CF*LANES-1:0]   cf_q_r;
  logic [SHARES*LANES-1:0] x_r;
  logic [SHARES*LANES-1:0] y_r;
  logic [SHARES*LANES-1:0] x_next_s;
  logic [SHARES*LANES-1:0] y_next_s;
  logic                    s2_free_s;
  logic                    s1_move_s;
  logic                    accept_s;

  assign s2_free_s  = ~s2_valid_r | out_ready_i;
  assign s1_move_s  = s1_valid_r & s2_free_s;
  assign in_ready_o = (~s1_valid_r | s2_free_s) & ~flush_i;
  assign accept_s   = in_valid_i & in_ready_o;
  // The upstream PRNG steps only when a beat is actually taken. Nothing is
  // taken while reset is asserted, even though in_ready_o reads 1.
  assign rnd_adv_o  = accept_s & rst_n;

  assign out_valid_o = s2_valid_r;
  assign x_o         = x_r;
  assign y_o         = y_r;

  // Compression trees: one 3-input XOR per output share, reading cf_q only.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
      localparam int unsigned XB = lane_base(l) + g * SHARES;
      localparam int unsigned YB = lane_base(l) + (g + GROUPS) * SHARES;
      cf_share_xor3 u_x (
        .cf_grp (cf_q_r[XB +: 3]),
        .share  (x_next_s[l * SHARES + X_SHARE_MAP[g]])
      );
      cf_share_xor3 u_y (
        .cf_grp (cf_q_r[YB +: 3]),
        .share  (y_next_s[l * SHARES + Y_SHARE_MAP[g]])
      );
    end
  end

  // Stage occupancy flags. Reset has top priority, then flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else if (flush_i) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else begin
      // A new accept wins over a same-cycle move-out, so S1 stays full.
      s1_valid_r <= accept_s | (s1_valid_r & ~s1_move_s);
      if (s2_free_s) begin
        s2_valid_r <= s1_move_s;
      end
    end
  end

  // Data registers: S1 captures raw CF bits, S2 captures compressed shares.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cf_q_r <= '0;
      x_r    <= '0;
      y_r    <= '0;
    end else if (flush_i) begin
`ifdef PRINCE_CF_ZEROIZE_EN
      cf_q_r <= '0;
      x_r    <= '0;
      y_r    <= '0;
`endif
    end else begin
      if (accept_s) begin
        cf_q_r <= cf_i;
`ifdef PRINCE_CF_ZEROIZE_EN
      end else if (s1_move_s) begin
        cf_q_r <= '0;
`endif
      end
      if (s1_move_s) begin
        x_r <= x_next_s;
        y_r <= y_next_s;
`ifdef PRINCE_CF_ZEROIZE_EN
      end else if (s2_free_s) begin
        x_r <= '0;
        y_r <= '0;
`endif
      end
    end
  end

endmodule
